// File: rtl/oled_tile_selector.sv
// rtl/oled_tile_selector.sv - push-button colour tiles with debounce and registered RGB565 pixel lookup
//
// Purpose:
//   A vertical stack of N_TILES square tiles. Each tile has a push-button.
//   An accepted press steps that tile through a colour palette. Each channel
//   has a lockout FSM (IDLE/LOCK/HELD). The block answers (x, y) pixel queries
//   with a registered RGB565 value. A match-indicator circle below the tiles
//   lights when every tile shows the same match colour (index 1 or 4).
//
// Optional feature:
//   TILE_AUTO_REPEAT_EN - when defined, a held button keeps stepping its tile
//   once every REPEAT_TICKS ticks after the lockout ends.
//
// Ports:
//   CLK         system clock, rising edge
//   RST_N       asynchronous active-low reset
//   tick_1ms    one-cycle enable pulse per millisecond
//   enable      1 = accept new presses
//   btn         raw active-high buttons, bit i drives tile i (tile 0 on top)
//   x, y        pixel query column 0..95, row 0..63
//   pixel_data  RGB565 for the (x, y) presented on the previous cycle
//   colour_idx  tile i colour index at bits [3i+2:3i]
//   match       all indices equal and equal to 1 or 4
module oled_tile_selector #(
  parameter int N_TILES        = 3,
  parameter int NUM_COLOURS    = 6,
  parameter int DEBOUNCE_TICKS = 200,
  parameter int REPEAT_TICKS   = 500,
  parameter int TILE_X0        = 42,
  parameter int TILE_Y0        = 3,
  parameter int TILE_SIZE      = 14,
  parameter int TILE_PITCH     = 16,
  parameter int CIRC_CX        = 48,
  parameter int CIRC_CY        = 56,
  parameter int CIRC_R2        = 42
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   tick_1ms,
  input  logic                   enable,
  input  logic [N_TILES-1:0]     btn,
  input  logic [6:0]             x,
  input  logic [5:0]             y,
  output logic [15:0]            pixel_data,
  output logic [3*N_TILES-1:0]   colour_idx,
  output logic                   match
);

  localparam int MAX_TICKS = (DEBOUNCE_TICKS > REPEAT_TICKS) ? DEBOUNCE_TICKS : REPEAT_TICKS;
  localparam int CW        = $clog2(MAX_TICKS + 1);
  localparam logic [CW-1:0] DEB_LOAD = CW'(DEBOUNCE_TICKS);
`ifdef TILE_AUTO_REPEAT_EN
  localparam logic [CW-1:0] REP_LOAD = CW'(REPEAT_TICKS);
`endif
  localparam logic [2:0] LAST_IDX = 3'(NUM_COLOURS - 1);

  typedef enum logic [1:0] {IDLE, LOCK, HELD} state_t;

  logic [N_TILES-1:0] sync_a, sync_b, prev, armed, rise;
  logic [1:0]         warm;

  state_t        state    [N_TILES];
  state_t        state_nx [N_TILES];
  logic [CW-1:0] cnt      [N_TILES];
  logic [CW-1:0] cnt_nx   [N_TILES];
  logic [2:0]    idx      [N_TILES];
  logic [2:0]    idx_nx   [N_TILES];

  function automatic logic [2:0] next_colour(input logic [2:0] c);
    return (c == LAST_IDX) ? 3'd0 : c + 3'd1;
  endfunction

  function automatic logic [15:0] palette(input logic [2:0] c);
    case (c)
      3'd0:    return 16'hFFFF;
      3'd1:    return 16'hF800;
      3'd2:    return 16'h07E0;
      3'd3:    return 16'h001F;
      3'd4:    return 16'hFD20;
      3'd5:    return 16'h0000;
      3'd6:    return 16'hFFE0;
      default: return 16'h07FF;
    endcase
  endfunction

  // Synchroniser, edge register and arming. 'warm' waits until the
  // synchroniser holds a real sample after reset. A channel arms only after
  // it has seen the button released, so a button held through reset cannot
  // produce a phantom rising edge.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync_a <= '0;
      sync_b <= '0;
      prev   <= '0;
      armed  <= '0;
      warm   <= '0;
    end else begin
      sync_a <= btn;
      sync_b <= sync_a;
      prev   <= sync_b;
      if (warm != 2'd2) warm <= warm + 2'd1;
      else              armed <= armed | ~sync_b;
    end
  end

  assign rise = sync_b & ~prev & armed;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < N_TILES; i++) begin
        state[i] <= IDLE;
        cnt[i]   <= '0;
        idx[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < N_TILES; i++) begin
        state[i] <= state_nx[i];
        cnt[i]   <= cnt_nx[i];
        idx[i]   <= idx_nx[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N_TILES; i++) begin
      state_nx[i] = state[i];
      cnt_nx[i]   = cnt[i];
      idx_nx[i]   = idx[i];
      case (state[i])
        IDLE: begin
          if (rise[i] && enable) begin
            idx_nx[i]   = next_colour(idx[i]);
            cnt_nx[i]   = DEB_LOAD;
            state_nx[i] = LOCK;
          end
        end
        LOCK: begin
          if (cnt[i] == '0) begin
            if (!sync_b[i]) begin
              state_nx[i] = IDLE;
            end else begin
              state_nx[i] = HELD;
`ifdef TILE_AUTO_REPEAT_EN
              cnt_nx[i]   = REP_LOAD;
`endif
            end
          end else if (tick_1ms) begin
            cnt_nx[i] = cnt[i] - CW'(1);
          end
        end
        HELD: begin
          if (!sync_b[i]) begin
            state_nx[i] = IDLE;
            cnt_nx[i]   = '0;
          end
`ifdef TILE_AUTO_REPEAT_EN
          // A repeat that falls due while disabled waits at zero until
          // enable returns.
          else if (cnt[i] == '0) begin
            if (enable) begin
              idx_nx[i] = next_colour(idx[i]);
              cnt_nx[i] = REP_LOAD;
            end
          end else if (tick_1ms) begin
            cnt_nx[i] = cnt[i] - CW'(1);
          end
`endif
        end
        default: begin
          state_nx[i] = IDLE;
          cnt_nx[i]   = '0;
        end
      endcase
    end
  end

  genvar g;
  generate
    for (g = 0; g < N_TILES; g++) begin : g_idx
      assign colour_idx[3*g +: 3] = idx[g];
    end
  endgenerate

  always_comb begin
    match = (idx[0] == 3'd1) || (idx[0] == 3'd4);
    for (int i = 1; i < N_TILES; i++) begin
      if (idx[i] != idx[0]) match = 1'b0;
    end
  end

  logic                tile_hit;
  logic [2:0]          tile_sel;
  logic signed [7:0]   dx, dy;
  logic [7:0]          adx, ady;
  logic [15:0]         dist2;
  logic                in_circle;
  logic [15:0]         pix_nx;

  // The lowest-numbered tile wins if tile regions ever overlap.
  always_comb begin
    tile_hit = 1'b0;
    tile_sel = '0;
    for (int i = 0; i < N_TILES; i++) begin
      if (!tile_hit &&
          int'(x) >= TILE_X0 && int'(x) <= TILE_X0 + TILE_SIZE - 1 &&
          int'(y) >= TILE_Y0 + i*TILE_PITCH &&
          int'(y) <= TILE_Y0 + i*TILE_PITCH + TILE_SIZE - 1) begin
        tile_hit = 1'b1;
        tile_sel = idx[i];
      end
    end
  end

  // Signed 8-bit differences. Squaring the magnitudes in 16 bits cannot
  // overflow, because the magnitudes are at most 128.
  assign dx        = $signed({1'b0, x}) - $signed(8'(CIRC_CX));
  assign dy        = $signed({2'b0, y}) - $signed(8'(CIRC_CY));
  assign adx       = dx[7] ? unsigned'(-dx) : unsigned'(dx);
  assign ady       = dy[7] ? unsigned'(-dy) : unsigned'(dy);
  assign dist2     = ({8'd0, adx} * {8'd0, adx}) + ({8'd0, ady} * {8'd0, ady});
  assign in_circle = (dist2 <= 16'(CIRC_R2));

  always_comb begin
    pix_nx = 16'h0000;
    if (tile_hit)                pix_nx = palette(tile_sel);
    else if (in_circle && match) pix_nx = palette(idx[0]);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) pixel_data <= 16'h0000;
    else        pixel_data <= pix_nx;
  end

endmodule

// File: tb/tb_oled_tile_selector.sv
// tb/tb_oled_tile_selector.sv - scoreboard bench for oled_tile_selector
module tb_oled_tile_selector;
  localparam int N = 3;

  logic           CLK = 1'b0;
  logic           RST_N = 1'b0;
  logic           tick_1ms = 1'b0;
  logic           enable = 1'b1;
  logic [N-1:0]   btn = '0;
  logic [6:0]     x = 7'd48;
  logic [5:0]     y = 6'd10;
  logic [15:0]    pixel_data;
  logic [3*N-1:0] colour_idx;
  logic           match;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_t;
  sb_t sb[$];

  oled_tile_selector dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .tick_1ms   (tick_1ms),
    .enable     (enable),
    .btn        (btn),
    .x          (x),
    .y          (y),
    .pixel_data (pixel_data),
    .colour_idx (colour_idx),
    .match      (match)
  );

  always #5 CLK = ~CLK;

  // A 1 ms tick every 10 clocks.
  initial begin
    forever begin
      repeat (9) @(negedge CLK);
      tick_1ms = 1'b1;
      @(negedge CLK);
      tick_1ms = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] pk(input int a0, input int a1, input int a2);
    return {3'(a2), 3'(a1), 3'(a0)};
  endfunction

  task automatic sb_pop_check(input logic [31:0] got);
    sb_t e;
    e = sb.pop_front();
    check(e.tag, got, e.exp);
  endtask

  task automatic wait_ticks(input int n);
    repeat (n * 10) @(negedge CLK);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST_N = 1'b0;
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    repeat (5) @(negedge CLK);
  endtask

  task automatic press(input logic [N-1:0] mask, input int ms);
    @(negedge CLK);
    btn = mask;
    wait_ticks(ms);
    btn = '0;
  endtask

  // Push the expected indices, press for 5 ms, settle, then compare.
  task automatic step_press(input logic [N-1:0] mask, input logic [8:0] e, input string tag);
    sb.push_back('{tag, 32'(e)});
    press(mask, 5);
    wait_ticks(10);
    sb_pop_check(32'(colour_idx));
  endtask

  task automatic query(input int qx, input int qy, input logic [15:0] e, input string tag);
    @(negedge CLK);
    x = 7'(qx);
    y = 6'(qy);
    sb.push_back('{tag, 32'(e)});
    @(negedge CLK);
    sb_pop_check(32'(pixel_data));
  endtask

  task automatic check_idx(input logic [8:0] e, input string tag);
    sb.push_back('{tag, 32'(e)});
    @(negedge CLK);
    sb_pop_check(32'(colour_idx));
  endtask

  initial begin
    // Reset state, with a tile pixel presented during reset.
    repeat (3) @(negedge CLK);
    check("rst_pix", 32'(pixel_data), 32'h0);
    check("rst_idx", 32'(colour_idx), 32'h0);
    check("rst_match", 32'(match), 32'h0);
    RST_N = 1'b1;
    repeat (5) @(negedge CLK);

    query(48, 10, 16'hFFFF, "t0_white");
    query(48, 25, 16'hFFFF, "t1_white");
    query(48, 40, 16'hFFFF, "t2_white");
    query(48, 56, 16'h0000, "circ_nomatch");
    check("match_idle", 32'(match), 32'h0);

    // Debounce lockout.
    step_press(3'b001, pk(1, 0, 0), "first_press");
    wait_ticks(85);
    step_press(3'b001, pk(1, 0, 0), "locked_press");
    wait_ticks(95);
    step_press(3'b001, pk(2, 0, 0), "after_lock");

    // Wrap sequence from a clean reset.
    do_reset();
    for (int k = 1; k <= 6; k++) begin
      step_press(3'b001, pk(k % 6, 0, 0), $sformatf("wrap%0d", k));
      if (k == 3) query(48, 10, 16'h001F, "t0_blue");
      wait_ticks(200);
    end

    // Simultaneous press, match and circle geometry.
    step_press(3'b111, pk(1, 1, 1), "simul");
    check("match_all1", 32'(match), 32'h1);
    query(48, 56, 16'hF800, "circ_centre");
    query(48, 62, 16'hF800, "circ_in_dy6");
    query(48, 63, 16'h0000, "circ_out_dy7");
    query(41, 56, 16'h0000, "circ_out_dx7");
    query(48, 25, 16'hF800, "t1_red");
    query(55, 16, 16'hF800, "t0_corner");
    query(56, 10, 16'h0000, "tile_x_edge");
    query(48, 17, 16'h0000, "tile_gap");
    wait_ticks(200);

    // A rising edge seen while disabled is discarded, even once enable returns.
    @(negedge CLK);
    enable = 1'b0;
    btn = 3'b010;
    wait_ticks(10);
    enable = 1'b1;
    wait_ticks(10);
    btn = '0;
    wait_ticks(5);
    check_idx(pk(1, 1, 1), "en_gated");
    check("match_kept", 32'(match), 32'h1);
    step_press(3'b010, pk(1, 2, 1), "en_restored");
    check("match_lost", 32'(match), 32'h0);
    query(48, 56, 16'h0000, "circ_nomatch2");

    // Reset during lockout returns the channel to IDLE at index 0.
    step_press(3'b001, pk(2, 2, 1), "pre_rst");
    wait_ticks(50);
    do_reset();
    check("rst_midlock", 32'(colour_idx), 32'h0);
    step_press(3'b001, pk(1, 0, 0), "idle_after_rst");

    // A button held through reset gives no increment until it is pressed again.
    @(negedge CLK);
    btn = 3'b100;
    wait_ticks(2);
    do_reset();
    wait_ticks(20);
    check_idx(pk(0, 0, 0), "held_over_rst");
    btn = '0;
    wait_ticks(2);
    step_press(3'b100, pk(0, 0, 1), "repress_after_rst");

    // Long hold on btn[2].
    do_reset();
    @(negedge CLK);
    btn = 3'b100;
    wait_ticks(100);
    check_idx(pk(0, 0, 1), "hold_t100");
    wait_ticks(550);
    check_idx(pk(0, 0, 1), "hold_t650");
    wait_ticks(100);
`ifdef TILE_AUTO_REPEAT_EN
    check_idx(pk(0, 0, 2), "hold_t750");
`else
    check_idx(pk(0, 0, 1), "hold_t750");
`endif
    wait_ticks(400);
`ifdef TILE_AUTO_REPEAT_EN
    check_idx(pk(0, 0, 2), "hold_t1150");
`else
    check_idx(pk(0, 0, 1), "hold_t1150");
`endif
    wait_ticks(100);
`ifdef TILE_AUTO_REPEAT_EN
    check_idx(pk(0, 0, 3), "hold_t1250");
`else
    check_idx(pk(0, 0, 1), "hold_t1250");
`endif
    wait_ticks(50);
    btn = '0;
    wait_ticks(5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
